fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, buffers in-order responses for decode,
// and redirects on taken branches while discarding responses still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    input  logic        pc_src,
    input  logic [31:0] br_pc,
    input  logic [31:0] imm_ext
);

    localparam int unsigned PtrW = (BUF_DEPTH == 4) ? 2 : 1;
    localparam int unsigned CntW = 3;

    typedef enum logic [0:0] {StResetWait, StFetch} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;

    logic [31:0] buf_instr_q [BUF_DEPTH];
    logic [31:0] buf_pc_q    [BUF_DEPTH];

    logic        req_acc;
    logic        push;
    logic        pop;
    logic [31:0] target;
    logic [CntW:0] credit_used;

    always_comb begin
        credit_used    = {1'b0, outstanding_q} + {1'b0, count_q};
        imem_req_valid = (state_q == StFetch) && (credit_used < (CntW + 1)'(BUF_DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_acc        = imem_req_valid && imem_req_ready;
        dec_valid      = (count_q != '0);
        // Redirect flushes the buffer, so neither a push nor a pop survives it.
        push           = imem_rsp_valid && !pc_src && (drop_cnt_q == '0);
        pop            = dec_valid && dec_ready && !pc_src;
        target         = (br_pc + imm_ext) & 32'hFFFF_FFFC;
        dec_instr      = dec_valid ? buf_instr_q[head_q] : '0;
        dec_pc         = dec_valid ? buf_pc_q[head_q] : '0;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;

        case (state_q)
            StResetWait: state_d = StFetch;
            StFetch:     state_d = StFetch;
            default:     state_d = StResetWait;
        endcase

        if (req_acc && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (!req_acc && imem_rsp_valid) begin
            outstanding_d = outstanding_q - CntW'(1);
        end

        if (pc_src) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_acc) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CntW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                tail_d   = tail_q + PtrW'(1);
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StResetWait;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    // Storage needs no reset: the outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[tail_q] <= imem_rsp_data;
            buf_pc_q[tail_q]    <= rsp_pc_q;
        end
    end

endmodule
